// File: rtl/aq_djpeg_fbwr_if.sv
// aq_djpeg_fbwr_if -- write-request bus from the frame-buffer writer to the
// memory interconnect.
//   WrValid  write request valid            (master -> slave)
//   WrReady  write request accepted         (slave  -> master)
//   WrAddr   32-bit byte address            (master -> slave)
//   WrData   32-bit pixel word {00,R,G,B}   (master -> slave)
interface aq_djpeg_fbwr_if;
  logic        WrValid;
  logic        WrReady;
  logic [31:0] WrAddr;
  logic [31:0] WrData;

  modport master (
    output WrValid,
    output WrAddr,
    output WrData,
    input  WrReady
  );

  modport slave (
    input  WrValid,
    input  WrAddr,
    input  WrData,
    output WrReady
  );
endinterface

// File: rtl/aq_djpeg_fbwr.sv
// aq_djpeg_fbwr -- frame-buffer writer behind the JPEG decoder.
// Captures decoded pixels, turns (X,Y) into a byte address in a linear
// 32-bit-per-pixel frame buffer, queues address/data pairs in a small FIFO
// and drains them over a valid/ready write port. The decoder cannot be
// stalled, so pixels arriving while everything is full are dropped and
// reported instead.
// Ports:
//   clk, rst             clock, synchronous active-low reset
//   Start                pulse: latch Base/Stride, flush pipeline/FIFO, clear stats
//   Base, Stride         frame buffer base address, bytes per line
//   PixEnable, PixX/Y,   decoded pixel strobe, coordinates, colour
//   PixR/G/B
//   wr                   write request bus (master side)
//   AlmostFull           FIFO occupancy >= depth - AFULL_MARGIN
//   Overflow             sticky: a pixel was dropped
//   PixelCount           pixels accepted (wraps)
//   DropCount            pixels dropped (saturates)
//   Busy                 anything still in flight
module aq_djpeg_fbwr #(
  parameter int FIFO_AW      = 4,
  parameter int AFULL_MARGIN = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            Start,
  input  logic [31:0]     Base,
  input  logic [15:0]     Stride,
  input  logic            PixEnable,
  input  logic [15:0]     PixX,
  input  logic [15:0]     PixY,
  input  logic [7:0]      PixR,
  input  logic [7:0]      PixG,
  input  logic [7:0]      PixB,
  aq_djpeg_fbwr_if.master wr,
  output logic            AlmostFull,
  output logic            Overflow,
  output logic [31:0]     PixelCount,
  output logic [15:0]     DropCount,
  output logic            Busy
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   FULL_LEVEL  = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   AFULL_LEVEL = (FIFO_AW + 1)'(DEPTH - AFULL_MARGIN);
  localparam logic [FIFO_AW:0]   CNT_ONE     = 1;
  localparam logic [FIFO_AW-1:0] PTR_ONE     = 1;

  // Latched frame geometry
  logic [31:0] baseR;
  logic [15:0] strideR;

  // Address pipeline
  logic        valid1;
  logic [15:0] x1;
  logic [23:0] rgb1;
  logic [31:0] prod1;
  logic        valid2;
  logic [31:0] addr2;
  logic [31:0] data2;

  // FIFO: {addr, data} per entry
  logic [63:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wrPtr;
  logic [FIFO_AW-1:0] rdPtr;
  logic [FIFO_AW:0]   count;

  logic fifoFull;
  logic fifoEmpty;
  logic outFree;
  logic pop;
  logic bypass;
  logic accept;
  logic push;
  logic drop;

  always_ff @(posedge clk) begin
    if (!rst) begin
      baseR   <= '0;
      strideR <= '0;
    end else if (Start) begin
      baseR   <= Base;
      strideR <= Stride;
    end
  end

  // Start also kills anything in flight, including a pixel arriving with it.
  always_ff @(posedge clk) begin
    if (!rst || Start) begin
      valid1 <= 1'b0;
      x1     <= '0;
      rgb1   <= '0;
      prod1  <= '0;
      valid2 <= 1'b0;
      addr2  <= '0;
      data2  <= '0;
    end else begin
      valid1 <= PixEnable;
      x1     <= PixX;
      rgb1   <= {PixR, PixG, PixB};
      prod1  <= {16'h0000, PixY} * {16'h0000, strideR};
      valid2 <= valid1;
      addr2  <= baseR + prod1 + {14'h0000, x1, 2'b00};
      data2  <= {8'h00, rgb1};
    end
  end

  assign fifoFull  = (count == FULL_LEVEL);
  assign fifoEmpty = (count == '0);
  // Output register can take a new word this cycle.
  assign outFree   = !wr.WrValid || wr.WrReady;
  assign pop       = outFree && !fifoEmpty;
  // With the FIFO empty, a fresh pixel goes straight to the output register,
  // giving the 3-cycle PixEnable -> WrValid latency.
  assign bypass    = outFree && fifoEmpty && valid2;
  // A full FIFO still accepts when its head leaves in the same cycle.
  assign accept    = valid2 && (!fifoFull || pop);
  assign push      = accept && !bypass;
  assign drop      = valid2 && fifoFull && !pop;

  always_ff @(posedge clk) begin
    if (!rst || Start) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      count      <= '0;
      wr.WrValid <= 1'b0;
      wr.WrAddr  <= '0;
      wr.WrData  <= '0;
      Overflow   <= 1'b0;
      PixelCount <= '0;
      DropCount  <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + PTR_ONE;
      end

      if (pop) begin
        rdPtr                  <= rdPtr + PTR_ONE;
        {wr.WrAddr, wr.WrData} <= mem[rdPtr];
        wr.WrValid             <= 1'b1;
      end else if (bypass) begin
        wr.WrAddr  <= addr2;
        wr.WrData  <= data2;
        wr.WrValid <= 1'b1;
      end else if (outFree) begin
        wr.WrValid <= 1'b0;
      end

      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase

      if (accept) begin
        PixelCount <= PixelCount + 32'd1;
      end

      if (drop) begin
        Overflow <= 1'b1;
        if (DropCount != 16'hFFFF) begin
          DropCount <= DropCount + 16'd1;
        end
      end
    end
  end

  // Storage array kept reset-free so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrPtr] <= {addr2, data2};
    end
  end

  assign AlmostFull = (count >= AFULL_LEVEL);
  assign Busy       = (count != '0) || valid1 || valid2 || wr.WrValid;

endmodule

// File: tb/tb_aq_djpeg_fbwr.sv
// tb_aq_djpeg_fbwr -- self-checking bench for aq_djpeg_fbwr.
// Expected write words are queued as pixels are driven and compared as the
// DUT hands them out; direct checks cover reset, latency, counters and flags.
module tb_aq_djpeg_fbwr;

  logic        clk = 1'b0;
  logic        rst;
  logic        Start;
  logic [31:0] Base;
  logic [15:0] Stride;
  logic        PixEnable;
  logic [15:0] PixX;
  logic [15:0] PixY;
  logic [7:0]  PixR;
  logic [7:0]  PixG;
  logic [7:0]  PixB;
  logic        AlmostFull;
  logic        Overflow;
  logic [31:0] PixelCount;
  logic [15:0] DropCount;
  logic        Busy;

  aq_djpeg_fbwr_if wrIf ();

  aq_djpeg_fbwr #(
    .FIFO_AW      (4),
    .AFULL_MARGIN (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .Start      (Start),
    .Base       (Base),
    .Stride     (Stride),
    .PixEnable  (PixEnable),
    .PixX       (PixX),
    .PixY       (PixY),
    .PixR       (PixR),
    .PixG       (PixG),
    .PixB       (PixB),
    .wr         (wrIf),
    .AlmostFull (AlmostFull),
    .Overflow   (Overflow),
    .PixelCount (PixelCount),
    .DropCount  (DropCount),
    .Busy       (Busy)
  );

  always #5 clk = ~clk;

  int          vecCnt = 0;
  int          missCnt = 0;
  int          writeCnt = 0;
  logic [63:0] sbQ [$];
  logic [31:0] mBase = '0;
  logic [15:0] mStride = '0;

  // Monitor state
  logic        holdPrev = 1'b0;
  logic [31:0] prevAddr = '0;
  logic [31:0] prevData = '0;
  logic [63:0] expEnt;

  task automatic checkVal(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vecCnt++;
    if (act !== exp) begin
      missCnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drivePix(input logic [15:0] x, input logic [15:0] y,
                          input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                          input bit expAcc);
    logic [31:0] a;
    PixEnable = 1'b1;
    PixX = x;
    PixY = y;
    PixR = r;
    PixG = g;
    PixB = b;
    a = mBase + 32'(y) * 32'(mStride) + (32'(x) << 2);
    if (expAcc) sbQ.push_back({a, 8'h00, r, g, b});
  endtask

  task automatic doStart(input logic [31:0] b, input logic [15:0] s);
    Start  = 1'b1;
    Base   = b;
    Stride = s;
    mBase  = b;
    mStride = s;
    sbQ.delete();
    tick();
    Start = 1'b0;
  endtask

  task automatic waitDrain(input int maxCyc, input bit toggle);
    int n = 0;
    PixEnable = 1'b0;
    while ((Busy || sbQ.size() != 0) && n < maxCyc) begin
      if (toggle) wrIf.WrReady = ~wrIf.WrReady;
      else        wrIf.WrReady = 1'b1;
      tick();
      n++;
    end
    checkVal("drain_busy", 64'(Busy), 64'd0);
    checkVal("drain_sb_left", 64'(sbQ.size()), 64'd0);
  endtask

  task automatic checkAllZero(input string tag);
    checkVal({tag, "_wrvalid"}, 64'(wrIf.WrValid), 64'd0);
    checkVal({tag, "_wraddr"},  64'(wrIf.WrAddr),  64'd0);
    checkVal({tag, "_wrdata"},  64'(wrIf.WrData),  64'd0);
    checkVal({tag, "_afull"},   64'(AlmostFull),   64'd0);
    checkVal({tag, "_ovf"},     64'(Overflow),     64'd0);
    checkVal({tag, "_pixcnt"},  64'(PixelCount),   64'd0);
    checkVal({tag, "_dropcnt"}, 64'(DropCount),    64'd0);
    checkVal({tag, "_busy"},    64'(Busy),         64'd0);
  endtask

  // Write-port monitor: one line per accepted write, scoreboard compare,
  // and hold-stability check while the slave stalls.
  always @(negedge clk) begin
    if (holdPrev) begin
      checkVal("hold_valid", 64'(wrIf.WrValid), 64'd1);
      checkVal("hold_addr",  64'(wrIf.WrAddr),  64'(prevAddr));
      checkVal("hold_data",  64'(wrIf.WrData),  64'(prevData));
    end
    if (wrIf.WrValid && wrIf.WrReady) begin
      writeCnt++;
      checkVal("sb_nonempty", 64'(sbQ.size() != 0), 64'd1);
      if (sbQ.size() != 0) begin
        expEnt = sbQ.pop_front();
        checkVal("wr_addr", 64'(wrIf.WrAddr), 64'(expEnt[63:32]));
        checkVal("wr_data", 64'(wrIf.WrData), 64'(expEnt[31:0]));
      end
      $display("write #%0d addr=%08h data=%08h", writeCnt, wrIf.WrAddr, wrIf.WrData);
    end
    holdPrev = wrIf.WrValid && !wrIf.WrReady && !Start && rst;
    prevAddr = wrIf.WrAddr;
    prevData = wrIf.WrData;
  end

  initial begin
    rst = 1'b0;
    Start = 1'b0;
    Base = '0;
    Stride = '0;
    PixEnable = 1'b0;
    PixX = '0;
    PixY = '0;
    PixR = '0;
    PixG = '0;
    PixB = '0;
    wrIf.WrReady = 1'b0;

    // Reset state
    tick();
    tick();
    checkAllZero("reset");
    rst = 1'b1;
    tick();

    // Single pixel, latency and address
    doStart(32'h1000_0000, 16'd64);
    wrIf.WrReady = 1'b1;
    drivePix(16'd3, 16'd2, 8'h11, 8'h22, 8'h33, 1'b1);
    tick();
    PixEnable = 1'b0;
    tick();
    checkVal("lat_early_valid", 64'(wrIf.WrValid), 64'd0);
    tick();
    checkVal("lat_valid", 64'(wrIf.WrValid), 64'd1);
    checkVal("lat_addr",  64'(wrIf.WrAddr),  64'h1000_008C);
    checkVal("lat_data",  64'(wrIf.WrData),  64'h0011_2233);
    checkVal("lat_pixcnt", 64'(PixelCount),  64'd1);
    waitDrain(20, 1'b0);

    // Overflow burst: 40 pixels, no ready
    doStart(32'h1000_0000, 16'd64);
    wrIf.WrReady = 1'b0;
    writeCnt = 0;
    for (int i = 0; i < 40; i++) begin
      drivePix(16'(i), 16'd5, 8'(i), 8'h5A, 8'(255 - i), i < 17);
      tick();
    end
    PixEnable = 1'b0;
    tick();
    tick();
    tick();
    checkVal("ovf_pixcnt",  64'(PixelCount), 64'd17);
    checkVal("ovf_dropcnt", 64'(DropCount),  64'd23);
    checkVal("ovf_flag",    64'(Overflow),   64'd1);
    checkVal("ovf_afull",   64'(AlmostFull), 64'd1);
    waitDrain(100, 1'b0);
    checkVal("ovf_writes", 64'(writeCnt), 64'd17);

    // Full FIFO with simultaneous pop: no drops
    doStart(32'h0800_0000, 16'd256);
    wrIf.WrReady = 1'b0;
    writeCnt = 0;
    for (int i = 0; i < 30; i++) begin
      drivePix(16'(i), 16'd1, 8'(i), 8'(i + 1), 8'(i + 2), 1'b1);
      wrIf.WrReady = (i >= 19);
      if (i == 25) checkVal("full_afull", 64'(AlmostFull), 64'd1);
      tick();
    end
    waitDrain(100, 1'b0);
    checkVal("full_dropcnt", 64'(DropCount),  64'd0);
    checkVal("full_ovf",     64'(Overflow),   64'd0);
    checkVal("full_pixcnt",  64'(PixelCount), 64'd30);
    checkVal("full_writes",  64'(writeCnt),   64'd30);

    // Address wrap
    doStart(32'hFFFF_FFF0, 16'd64);
    wrIf.WrReady = 1'b1;
    drivePix(16'd8, 16'd0, 8'hAA, 8'hBB, 8'hCC, 1'b1);
    tick();
    PixEnable = 1'b0;
    tick();
    tick();
    checkVal("wrap_addr", 64'(wrIf.WrAddr), 64'h0000_0010);
    waitDrain(20, 1'b0);

    // Toggling ready
    doStart(32'h1000_0000, 16'd64);
    writeCnt = 0;
    for (int i = 0; i < 8; i++) begin
      drivePix(16'(i), 16'd4, 8'(8'h40 + i), 8'(8'h50 + i), 8'(8'h60 + i), 1'b1);
      wrIf.WrReady = (i % 2 == 1);
      tick();
    end
    waitDrain(60, 1'b1);
    checkVal("tog_writes", 64'(writeCnt), 64'd8);

    // Start aborts queued work
    wrIf.WrReady = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drivePix(16'(i), 16'd7, 8'(i), 8'h00, 8'hFF, 1'b1);
      tick();
    end
    PixEnable = 1'b0;
    tick();
    tick();
    tick();
    checkVal("abort_pre_valid", 64'(wrIf.WrValid), 64'd1);
    checkVal("abort_pre_busy",  64'(Busy),         64'd1);
    drivePix(16'd9, 16'd9, 8'h01, 8'h02, 8'h03, 1'b0);
    doStart(32'h2000_0000, 16'd128);
    PixEnable = 1'b0;
    checkVal("abort_valid",   64'(wrIf.WrValid), 64'd0);
    checkVal("abort_busy",    64'(Busy),         64'd0);
    checkVal("abort_pixcnt",  64'(PixelCount),   64'd0);
    checkVal("abort_dropcnt", 64'(DropCount),    64'd0);
    tick();
    tick();
    checkVal("abort_busy_late", 64'(Busy), 64'd0);
    wrIf.WrReady = 1'b1;
    drivePix(16'd5, 16'd3, 8'h77, 8'h88, 8'h99, 1'b1);
    tick();
    PixEnable = 1'b0;
    tick();
    tick();
    checkVal("abort_new_addr", 64'(wrIf.WrAddr), 64'h2000_0194);
    waitDrain(20, 1'b0);

    // Reset mid-burst
    doStart(32'h3000_0000, 16'd32);
    wrIf.WrReady = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drivePix(16'(i), 16'd2, 8'(i), 8'(i), 8'(i), 1'b1);
      if (i == 9) rst = 1'b0;
      tick();
    end
    checkAllZero("midrst");
    rst = 1'b1;
    PixEnable = 1'b0;
    sbQ.delete();
    mBase = '0;
    mStride = '0;
    tick();
    wrIf.WrReady = 1'b1;
    drivePix(16'd1, 16'd1, 8'h12, 8'h34, 8'h56, 1'b1);
    tick();
    PixEnable = 1'b0;
    tick();
    tick();
    checkVal("postrst_addr", 64'(wrIf.WrAddr), 64'h0000_0004);
    checkVal("postrst_data", 64'(wrIf.WrData), 64'h0012_3456);
    waitDrain(20, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
    $finish;
  end

endmodule

// File: doc/aq_djpeg_fbwr.md
# aq_djpeg_fbwr

Frame-buffer writer placed directly downstream of the JPEG decoder top. It captures each decoded pixel (enable, X/Y, R/G/B), computes the pixel's byte address in a linear 32-bit-per-pixel frame buffer, and queues address/data pairs in a small FIFO. The FIFO drains through a valid/ready write port to the memory interconnect. The decoder output has no backpressure, so the block reports overflow and fill level instead of stalling its source.

## Interface
- FIFO_AW, 4: log2 of FIFO depth (16 entries).
- AFULL_MARGIN, 4: AlmostFull asserts when occupancy ≥ depth − AFULL_MARGIN.
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  reset, synchronous, active-low.
- Start  in  1  one-cycle pulse: latch Base/Stride, flush pipeline and FIFO, clear counters/flags.
- Base  in  32  frame buffer byte base address.
- Stride  in  16  bytes per image line.
- PixEnable  in  1  pixel valid (decoder OutEnable).
- PixX, PixY  in  16 each  pixel coordinates.
- PixR, PixG, PixB  in  8 each  pixel colour.
- WrValid  out  1  write request valid.
- WrReady  in  1  write request accepted.
- WrAddr  out  32  byte address.
- WrData  out  32  {8'h00, R, G, B}.
- AlmostFull  out  1  fill-level warning.
- Overflow  out  1  sticky: at least one pixel dropped since Start/reset.
- PixelCount  out  32  pixels accepted into the FIFO.
- DropCount  out  16  pixels dropped, saturates at 16'hFFFF.
- Busy  out  1  pipeline or FIFO non-empty.

## Operation
- Latched registers BaseR/StrideR load only on Start. Reset value is 0.
- Stage 1, registered: valid1 = PixEnable. Stores X, RGB, and prod = PixY × StrideR as a 32-bit product, truncated.
- Stage 2, registered: valid2 = valid1. addr = BaseR + prod + {X, 2'b00}, all mod 2^32. data = {8'h00, R, G, B}.
- Push: when valid2 is set and the FIFO is not full, write into FIFO and increment PixelCount (wraps at 2^32).
- Drop: when valid2 is set, the FIFO is full, and no pop occurs that cycle, the pixel is discarded, Overflow is set, and DropCount increments (saturating).
- Full with pop in the same cycle: push is accepted and occupancy is unchanged.
- FIFO: circular buffer with FIFO_AW-bit read/write pointers plus an occupancy counter (FIFO_AW+1 bits). Pointers wrap naturally.
- Output register holds the FIFO head in show-ahead fashion. WrValid/WrAddr/WrData refill from the FIFO when the output register is empty or when WrValid and WrReady are both high.
- While WrValid is high and WrReady is low, WrAddr and WrData stay stable.
- Start: valid1, valid2, the FIFO, the output register, Overflow, PixelCount and DropCount clear on the next edge. WrValid drops even mid-handshake; this abort is intentional. A PixEnable in the same cycle as Start is discarded.
- AlmostFull and Busy are combinational from occupancy, valid1, valid2 and WrValid.

## Timing
- Reset (rst = 0 at an edge): all outputs 0, BaseR = 0, StrideR = 0. Reset overrides Start.
- Latency: PixEnable in cycle N → valid1 in N+1 → valid2 in N+2 → FIFO write at end of N+2 → WrValid high in N+3, given FIFO empty and output register empty.
- Throughput: one pixel per cycle in, one write per cycle out while WrReady = 1.
- Ordering: writes leave in pixel-arrival order. Dropped pixels leave no gap marker.
- Start in cycle S: Busy = 0 from S+1 until the next PixEnable.

## Test plan
- Reset, then Start with Base = 0x1000_0000, Stride = 64. Pixel (X = 3, Y = 2, RGB = 11/22/33) with WrReady = 1 → WrValid in cycle +3, WrAddr = 0x1000_008C, WrData = 0x0011_2233, PixelCount = 1.
- Burst of 40 consecutive pixels with WrReady held 0 → 16 in the FIFO + 1 in the output register accepted (PixelCount = 17), DropCount = 23, Overflow = 1, AlmostFull = 1. Then WrReady = 1 → exactly 17 writes, in order.
- FIFO full, then WrReady = 1 while a new pixel arrives every cycle → no drops, occupancy stays at 16, DropCount unchanged.
- Address wrap: Base = 0xFFFF_FFF0, X = 8, Y = 0 → WrAddr = 0x0000_0010.
- WrReady toggling 1/0 every cycle over 8 pixels → each WrAddr/WrData holds while WrReady = 0. Eight writes in order, no duplicates.
- Start asserted with 5 entries queued and WrValid high → next cycle WrValid = 0, Busy = 0, counts = 0. A subsequent pixel uses the new Base/Stride.
- rst = 0 asserted mid-burst → all outputs 0 next cycle. Start is required before addresses use a non-zero Base.
